// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic feed controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } feed_state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_ROWS  = 4;
  localparam int unsigned DEF_COLS  = 4;
  localparam int unsigned DEF_DEPTH = 8;

endpackage

// File: rtl/skew_delay.sv
// Triangular skew line: lane r presents the entry vector's lane-r element
// r cycles after it entered. Lane 0 is combinational pass-through.
module skew_delay
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ROWS  = DEF_ROWS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_shift,
  input  logic                  i_clear,
  input  logic [ROWS*WIDTH-1:0] i_entry,
  output logic [ROWS*WIDTH-1:0] o_lane
);

  assign o_lane[WIDTH-1:0] = i_entry[WIDTH-1:0];

  for (genvar r = 1; r < ROWS; r++) begin : g_lane
    logic [WIDTH-1:0] r_stage [r];

    // lane r delay chain: zero on reset/clear, advance one stage per shift
    always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
        for (int unsigned s = 0; s < r; s++) r_stage[s] <= '0;
      end else if (i_shift) begin
        r_stage[0] <= i_entry[r*WIDTH +: WIDTH];
        for (int unsigned s = 1; s < r; s++) r_stage[s] <= r_stage[s-1];
      end
    end

    assign o_lane[r*WIDTH +: WIDTH] = r_stage[r-1];
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Tile sequencer for a systolic array: accepts up to DEPTH operand vectors,
// skews them across the row lanes, flushes the array and pulses done.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned DEPTH = DEF_DEPTH,
  // derived from the geometry above; not meant to be overridden
  parameter int unsigned CNTW  = $clog2(DEPTH + ROWS + COLS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNTW-1:0]       k_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ROWS*WIDTH-1:0] a_data,
  output logic [ROWS-1:0]       lane_load,
  output logic [ROWS*WIDTH-1:0] lane_pload,
  output logic                  acc_clear,
  output logic                  acc_en
);

  localparam logic [CNTW-1:0] DEPTH_C    = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] FLUSH_LAST = CNTW'(ROWS - 1 + COLS - 1);

  feed_state_t r_state;
  feed_state_t w_next;

  logic [CNTW-1:0] r_kl;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] r_flush;

  logic                  w_xfer;
  logic                  w_feed_last;
  logic                  w_flush_last;
  logic                  w_active;
  logic                  w_clear;
  logic [ROWS*WIDTH-1:0] w_entry;

  assign w_xfer       = (r_state == FEED) && a_valid;
  assign w_feed_last  = w_xfer && ((r_cnt + CNTW'(1)) == r_kl);
  assign w_flush_last = (r_flush == FLUSH_LAST);
  assign w_active     = (r_state == FEED) || (r_state == FLUSH);
  assign w_clear      = (r_state == IDLE) || (r_state == CLEAR);
  // stalled FEED cycles inject a zero bubble so the lane skew stays aligned
  assign w_entry      = w_xfer ? a_data : '0;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CLEAR;
      CLEAR:   w_next = (r_kl != '0) ? FEED : FLUSH;
      FEED:    if (w_feed_last) w_next = FLUSH;
      FLUSH:   if (w_flush_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // tile length latch, transfer counter and flush counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_kl    <= '0;
      r_cnt   <= '0;
      r_flush <= '0;
    end else begin
      if ((r_state == IDLE) && start)
        r_kl <= (k_len > DEPTH_C) ? DEPTH_C : k_len;
      if (r_state != FEED) r_cnt <= '0;
      else if (w_xfer)     r_cnt <= r_cnt + CNTW'(1);
      if (r_state != FLUSH) r_flush <= '0;
      else                  r_flush <= r_flush + CNTW'(1);
    end
  end

  // state-decoded control outputs
  always_comb begin
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    a_ready   = (r_state == FEED);
    acc_clear = (r_state == CLEAR);
    acc_en    = w_active;
    lane_load = w_active ? '1 : '0;
  end

  skew_delay #(
    .WIDTH (WIDTH),
    .ROWS  (ROWS)
  ) u_skew (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_shift (w_active),
    .i_clear (w_clear),
    .i_entry (w_entry),
    .o_lane  (lane_pload)
  );

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed + randomized bench for systolic_feed_ctrl against a schedule model.
module tb_systolic_feed_ctrl;
  import systolic_pkg::*;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNTW    = $clog2(DEPTH + ROWS + COLS + 1);
  localparam int          FLUSH_N = ROWS - 1 + COLS;
  localparam int          NOFF    = 128;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [CNTW-1:0]       k_len;
  logic                  busy;
  logic                  done;
  logic                  a_valid;
  logic                  a_ready;
  logic [ROWS*WIDTH-1:0] a_data;
  logic [ROWS-1:0]       lane_load;
  logic [ROWS*WIDTH-1:0] lane_pload;
  logic                  acc_clear;
  logic                  acc_en;

  int n_checks = 0;
  int n_errors = 0;

  logic [ROWS*WIDTH-1:0] ent [NOFF];
  bit                    vpat [NOFF];
  bit                    spat [NOFF];

  always #5 clk = ~clk;

  systolic_feed_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .lane_load  (lane_load),
    .lane_pload (lane_pload),
    .acc_clear  (acc_clear),
    .acc_en     (acc_en)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plan a tile from the valid pattern (offsets relative to the start cycle),
  // then drive it cycle by cycle and compare every output to the plan.
  // rst_off >= 0 pulses reset low during that offset; extra pulses start
  // during FEED and DONE.
  task automatic run_tile(input int k, input int rst_off, input bit extra);
    int kl, fl, dn, nx, last, obs_x;
    kl = (k > DEPTH) ? DEPTH : k;
    nx = 0;
    fl = 1;
    for (int o = 2; o < NOFF && nx < kl; o++)
      if (vpat[o]) begin nx++; fl = o; end
    dn   = fl + 1 + FLUSH_N;
    last = (rst_off >= 0) ? rst_off + 3 : dn + 3;
    for (int o = 0; o < NOFF; o++) begin ent[o] = '0; spat[o] = 1'b0; end
    if (extra) begin spat[3] = 1'b1; spat[dn] = 1'b1; end
    obs_x = 0;
    for (int o = 0; o <= last; o++) begin
      logic [63:0]           rnd;
      logic [ROWS*WIDTH-1:0] d, tmp, e_pl;
      bit                    act, xf, e_en;
      rnd     = {$urandom, $urandom};
      d       = rnd[ROWS*WIDTH-1:0];
      act     = (rst_off < 0) || (o <= rst_off);
      start   = (o == 0) || spat[o];
      a_valid = vpat[o];
      a_data  = d;
      k_len   = CNTW'(k);
      reset   = (o != rst_off);
      xf      = act && vpat[o] && (o >= 2) && (o <= fl);
      if (xf) ent[o] = d;
      e_en = act && (o >= 2) && (o < dn);
      e_pl = '0;
      if (act)
        for (int r = 0; r < ROWS; r++)
          if (o >= r) begin
            tmp = ent[o - r];
            e_pl[r*WIDTH +: WIDTH] = tmp[r*WIDTH +: WIDTH];
          end
      @(negedge clk);
      if (a_valid && a_ready) obs_x++;
      chk($sformatf("busy@%0d", o),      64'(busy),       64'(act && o >= 1 && o <= dn));
      chk($sformatf("done@%0d", o),      64'(done),       64'(act && o == dn));
      chk($sformatf("acc_clear@%0d", o), 64'(acc_clear),  64'(act && o == 1));
      chk($sformatf("a_ready@%0d", o),   64'(a_ready),    64'(act && o >= 2 && o <= fl));
      chk($sformatf("acc_en@%0d", o),    64'(acc_en),     64'(e_en));
      chk($sformatf("lane_load@%0d", o), 64'(lane_load),  e_en ? 64'((1 << ROWS) - 1) : 64'(0));
      chk($sformatf("lane_pload@%0d", o), 64'(lane_pload), 64'(e_pl));
      @(posedge clk);
      #1;
    end
    if (rst_off < 0) chk($sformatf("xfers_k%0d", k), 64'(obs_x), 64'(kl));
    reset   = 1'b1;
    start   = 1'b0;
    a_valid = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    a_valid = 1'b0;
    k_len   = '0;
    a_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy",   64'(busy),       64'(0));
    chk("rst_done",   64'(done),       64'(0));
    chk("rst_ready",  64'(a_ready),    64'(0));
    chk("rst_load",   64'(lane_load),  64'(0));
    chk("rst_pload",  64'(lane_pload), 64'(0));
    chk("rst_accen",  64'(acc_en),     64'(0));
    chk("rst_accclr", 64'(acc_clear),  64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // k=3, always valid: done at T+12
    for (int o = 0; o < NOFF; o++) vpat[o] = 1'b1;
    run_tile(3, -1, 1'b0);

    // k=3, two stall cycles after the first vector: done at T+14
    vpat[3] = 1'b0;
    vpat[4] = 1'b0;
    run_tile(3, -1, 1'b0);

    // empty tile: CLEAR then flush only, done at T+9
    for (int o = 0; o < NOFF; o++) vpat[o] = 1'b1;
    run_tile(0, -1, 1'b0);

    // oversized k clamps to DEPTH: done at T+17
    run_tile(20, -1, 1'b0);

    // start pulses during FEED and DONE are ignored
    run_tile(5, -1, 1'b1);

    // reset mid-FEED aborts the tile, then a fresh tile runs normally
    run_tile(6, 4, 1'b0);
    run_tile(4, -1, 1'b0);

    // randomized tiles with random valid patterns
    for (int t = 0; t < 6; t++) begin
      for (int o = 0; o < NOFF; o++) vpat[o] = (o >= 40) || ($urandom_range(0, 3) != 0);
      run_tile($urandom_range(0, 12), -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
